// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul display sequencer.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CAPTURE     = 3'd1,
    ST_START       = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_WAIT_VBLANK = 3'd4,
    ST_COMMIT      = 3'd5
  } seq_state_e;

  localparam int DEF_N       = 3;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 1024;
  localparam int MAT_W       = DEF_N * DEF_N * DEF_WIDTH;

  // Counter width able to hold 0 .. limit-1, never narrower than one bit.
  function automatic int timer_width(input int limit);
    if (limit > 1) begin
      return $clog2(limit);
    end else begin
      return 1;
    end
  endfunction

  localparam int TIMER_W = timer_width(DEF_TIMEOUT);

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: pulses for the cycle where d is 1 and its
// previous-cycle copy was 0.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_r;

  // One-cycle history of the monitored input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_r <= 1'b0;
    end else begin
      d_r <= d;
    end
  end

  assign rise = d & ~d_r;

endmodule

// File: rtl/matmul_display_sequencer.sv
// Run controller between the matrix source, the Cannon engine and the digit
// display; snapshots are only committed during vertical blanking.
module matmul_display_sequencer
  import matmul_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int START_CYCLES = 17,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int AUTO_RERUN   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_req,
  input  logic                   read_ready,
  input  logic [N*N*WIDTH-1:0]   mat_a_in,
  input  logic [N*N*WIDTH-1:0]   mat_b_in,
  input  logic                   vblank,
  output logic                   eng_start,
  output logic                   eng_read_ready,
  output logic [N*N*WIDTH-1:0]   eng_mat_a,
  output logic [N*N*WIDTH-1:0]   eng_mat_b,
  input  logic                   eng_done,
  input  logic [N*N*WIDTH-1:0]   eng_result,
  output logic [N*N*WIDTH-1:0]   disp_a,
  output logic [N*N*WIDTH-1:0]   disp_b,
  output logic [N*N*WIDTH-1:0]   disp_c,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [7:0]             run_count
);

  localparam int MB = N * N * WIDTH;
  localparam int TW = timer_width(TIMEOUT);
  localparam int SW = timer_width(START_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
  localparam logic          AUTO_S     = (AUTO_RERUN != 0);

  seq_state_e    state_r, next_state_s;
  logic          pend_r;
  logic [SW-1:0] start_cnt_r;
  logic [TW-1:0] timer_r;
  logic [MB-1:0] c_r;
  logic          done_rise_s;
  logic          launch_s;

  rise_detect u_done_rise (
    .clk   (clk),
    .reset (reset),
    .d     (eng_done),
    .rise  (done_rise_s)
  );

  assign launch_s = (run_req | pend_r | AUTO_S) & read_ready;

  // Next-state decode; a done edge takes priority over the timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) next_state_s = ST_CAPTURE;
        else          next_state_s = ST_IDLE;
      end
      ST_CAPTURE: next_state_s = ST_START;
      ST_START: begin
        if (start_cnt_r == START_LAST) next_state_s = ST_WAIT_DONE;
        else                           next_state_s = ST_START;
      end
      ST_WAIT_DONE: begin
        if (done_rise_s)                next_state_s = ST_WAIT_VBLANK;
        else if (timer_r == TIMER_LAST) next_state_s = ST_IDLE;
        else                            next_state_s = ST_WAIT_DONE;
      end
      ST_WAIT_VBLANK: begin
        if (vblank) next_state_s = ST_COMMIT;
        else        next_state_s = ST_WAIT_VBLANK;
      end
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // State, request latch, counters and handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      pend_r         <= 1'b0;
      start_cnt_r    <= '0;
      timer_r        <= '0;
      eng_start      <= 1'b0;
      eng_read_ready <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s == ST_CAPTURE) pend_r <= 1'b0;
      else if (run_req)               pend_r <= 1'b1;
      else                            pend_r <= pend_r;
      if (state_r == ST_START) start_cnt_r <= start_cnt_r + SW'(1);
      else                     start_cnt_r <= '0;
      if (state_r == ST_WAIT_DONE) timer_r <= timer_r + TW'(1);
      else                         timer_r <= '0;
      eng_start      <= (next_state_s == ST_START);
      eng_read_ready <= (next_state_s != ST_IDLE);
      busy           <= (next_state_s != ST_IDLE);
    end
  end

  // Operand capture, result latch, display commit and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_mat_a   <= '0;
      eng_mat_b   <= '0;
      c_r         <= '0;
      disp_a      <= '0;
      disp_b      <= '0;
      disp_c      <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      run_count   <= 8'd0;
    end else begin
      case (state_r)
        ST_CAPTURE: begin
          eng_mat_a   <= mat_a_in;
          eng_mat_b   <= mat_b_in;
          done        <= 1'b0;
          timeout_err <= 1'b0;
        end
        ST_WAIT_DONE: begin
          if (done_rise_s)                c_r         <= eng_result;
          else if (timer_r == TIMER_LAST) timeout_err <= 1'b1;
          else                            c_r         <= c_r;
        end
        ST_COMMIT: begin
          disp_a    <= eng_mat_a;
          disp_b    <= eng_mat_b;
          disp_c    <= c_r;
          done      <= 1'b1;
          run_count <= run_count + 8'd1;
        end
        default: begin
          c_r <= c_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_display_sequencer.sv
// Directed bench for matmul_display_sequencer with an in-line engine model
// and a scoreboard of expected display snapshots.
module tb_matmul_display_sequencer;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int MB = N * N * W;
  localparam int SC = 17;
  localparam int TO = 64;

  typedef struct packed {
    logic [MB-1:0] a;
    logic [MB-1:0] b;
    logic [MB-1:0] c;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, run_req, read_ready, vblank, eng_done;
  logic [MB-1:0] mat_a_in, mat_b_in, eng_result;
  logic          eng_start, eng_read_ready, busy, done, timeout_err;
  logic [MB-1:0] eng_mat_a, eng_mat_b, disp_a, disp_b, disp_c;
  logic [7:0]    run_count;

  int            total = 0;
  int            bad   = 0;
  exp_t          exp_q[$];
  logic [MB-1:0] last_a, last_b, last_c;
  logic [MB-1:0] ma, mb, ma2;

  always #5 clk = ~clk;

  matmul_display_sequencer #(
    .N(N), .WIDTH(W), .START_CYCLES(SC), .TIMEOUT(TO), .AUTO_RERUN(0)
  ) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .read_ready(read_ready),
    .mat_a_in(mat_a_in), .mat_b_in(mat_b_in), .vblank(vblank),
    .eng_start(eng_start), .eng_read_ready(eng_read_ready),
    .eng_mat_a(eng_mat_a), .eng_mat_b(eng_mat_b),
    .eng_done(eng_done), .eng_result(eng_result),
    .disp_a(disp_a), .disp_b(disp_b), .disp_c(disp_c),
    .busy(busy), .done(done), .timeout_err(timeout_err), .run_count(run_count)
  );

  function automatic logic [MB-1:0] matmul(input logic [MB-1:0] a, input logic [MB-1:0] b);
    logic [MB-1:0] c;
    logic [W-1:0]  sum;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum = '0;
        for (int k = 0; k < N; k++) sum = sum + a[(i*N+k)*W +: W] * b[(k*N+j)*W +: W];
        c[(i*N+j)*W +: W] = sum;
      end
    end
    return c;
  endfunction

  function automatic logic [MB-1:0] ramp(input int base);
    logic [MB-1:0] m;
    m = '0;
    for (int i = 0; i < N*N; i++) m[i*W +: W] = W'(base + i);
    return m;
  endfunction

  function automatic logic [MB-1:0] ident();
    logic [MB-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*W +: W] = 16'd1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [MB-1:0] a, input logic [MB-1:0] b);
    mat_a_in = a;
    mat_b_in = b;
    run_req  = 1'b1;
    exp_q.push_back('{a: a, b: b, c: matmul(a, b)});
    tick();
    run_req = 1'b0;
  endtask

  // mode 0: done 40 cycles after start falls; 1: never done; 2: done held high from START.
  task automatic run_engine(input int mode, input int pulses, input logic [MB-1:0] c);
    int n;
    n = 0;
    while (eng_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("start_seen", MB'(eng_start), MB'(1'b1));
    if (mode == 2) eng_done = 1'b1;
    n = 0;
    while (eng_start === 1'b1 && n < 100) begin
      if (pulses > 0 && n >= 2 && n < 2 + 2*pulses) run_req = (n % 2 == 0);
      else run_req = 1'b0;
      tick();
      n++;
    end
    run_req = 1'b0;
    chk("start_len", MB'(n), MB'(SC));
    if (mode == 0) begin
      repeat (39) tick();
      eng_result = c;
      eng_done   = 1'b1;
      tick();
      tick();
      eng_done = 1'b0;
    end
  endtask

  task automatic commit_check(input logic [7:0] exp_rc);
    exp_t e;
    int   n;
    repeat (5) tick();
    chk("vblank_wait_busy", MB'(busy), MB'(1'b1));
    chk("disp_c_hold", disp_c, last_c);
    vblank = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    vblank = 1'b0;
    chk("done_set", MB'(done), MB'(1'b1));
    chk("busy_after_commit", MB'(busy), MB'(1'b0));
    chk("rr_after_commit", MB'(eng_read_ready), MB'(1'b0));
    chk("run_count", MB'(run_count), MB'(exp_rc));
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=commit expected=none");
    end else begin
      e = exp_q.pop_front();
      chk("disp_a", disp_a, e.a);
      chk("disp_b", disp_b, e.b);
      chk("disp_c", disp_c, e.c);
      last_a = e.a;
      last_b = e.b;
      last_c = e.c;
    end
  endtask

  task automatic timeout_check(input logic [7:0] exp_rc);
    int n;
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", MB'(n), MB'(TO));
    chk("timeout_busy", MB'(busy), MB'(1'b0));
    chk("timeout_done", MB'(done), MB'(1'b0));
    chk("timeout_disp_a", disp_a, last_a);
    chk("timeout_disp_b", disp_b, last_b);
    chk("timeout_disp_c", disp_c, last_c);
    chk("timeout_run_count", MB'(run_count), MB'(exp_rc));
    void'(exp_q.pop_back());
  endtask

  initial begin
    int idle_bad;
    reset = 1'b0; run_req = 1'b0; read_ready = 1'b0; vblank = 1'b0; eng_done = 1'b0;
    mat_a_in = '0; mat_b_in = '0; eng_result = '0;
    last_a = '0; last_b = '0; last_c = '0;
    repeat (3) tick();
    chk("rst_busy", MB'(busy), MB'(1'b0));
    chk("rst_start", MB'(eng_start), MB'(1'b0));
    chk("rst_disp_c", disp_c, '0);
    chk("rst_run_count", MB'(run_count), '0);
    reset = 1'b1;
    tick();

    // Basic run: A = 1..9, B = identity.
    ma = ramp(1);
    mb = ident();
    read_ready = 1'b1;
    launch(ma, mb);
    chk("capture_busy", MB'(busy), MB'(1'b1));
    chk("capture_rr", MB'(eng_read_ready), MB'(1'b1));
    chk("capture_start", MB'(eng_start), MB'(1'b0));
    run_engine(0, 0, matmul(ma, mb));
    chk("eng_mat_a", eng_mat_a, ma);
    chk("eng_mat_b", eng_mat_b, mb);
    commit_check(8'd1);

    // Request while operands are not ready, held back 50 cycles.
    ma = ramp(20);
    mb = ramp(3);
    mat_a_in = ma;
    mat_b_in = mb;
    read_ready = 1'b0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    idle_bad = 0;
    repeat (50) begin
      if (busy !== 1'b0 || eng_start !== 1'b0) idle_bad++;
      tick();
    end
    chk("no_activity", MB'(idle_bad), '0);
    read_ready = 1'b1;
    exp_q.push_back('{a: ma, b: mb, c: matmul(ma, mb)});
    tick();
    chk("pend_capture", MB'(busy), MB'(1'b1));
    tick();
    mat_a_in = ramp(100);
    read_ready = 1'b0;
    run_engine(0, 0, matmul(ma, mb));
    chk("operands_held", eng_mat_a, ma);
    commit_check(8'd2);
    read_ready = 1'b1;
    tick();
    chk("rr_low_no_rerun", MB'(busy), MB'(1'b0));

    // Engine never completes.
    launch(ramp(5), ident());
    run_engine(1, 0, '0);
    timeout_check(8'd2);

    // Done already high before WAIT_DONE must not be accepted.
    launch(ramp(7), ident());
    run_engine(2, 0, '0);
    timeout_check(8'd2);
    eng_done = 1'b0;
    tick();

    // Three requests during a run collapse into one rerun.
    ma = ramp(2);
    mb = ramp(9);
    launch(ma, mb);
    run_engine(0, 3, matmul(ma, mb));
    ma2 = ramp(40);
    mat_a_in = ma2;
    exp_q.push_back('{a: ma2, b: mb, c: matmul(ma2, mb)});
    commit_check(8'd3);
    run_engine(0, 0, matmul(ma2, mb));
    commit_check(8'd4);
    idle_bad = 0;
    repeat (50) begin
      if (busy !== 1'b0) idle_bad++;
      tick();
    end
    chk("no_third_run", MB'(idle_bad), '0);

    // Reset while a result waits for vblank.
    launch(ramp(11), ident());
    run_engine(0, 0, matmul(ramp(11), ident()));
    repeat (3) tick();
    chk("pre_reset_busy", MB'(busy), MB'(1'b1));
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", MB'(busy), '0);
    chk("mid_rst_rr", MB'(eng_read_ready), '0);
    chk("mid_rst_eng_a", eng_mat_a, '0);
    chk("mid_rst_disp_a", disp_a, '0);
    chk("mid_rst_disp_b", disp_b, '0);
    chk("mid_rst_disp_c", disp_c, '0);
    chk("mid_rst_done", MB'(done), '0);
    chk("mid_rst_run_count", MB'(run_count), '0);
    exp_q.delete();
    read_ready = 1'b0;
    tick();
    reset = 1'b1;
    vblank = 1'b1;
    repeat (20) tick();
    vblank = 1'b0;
    chk("post_rst_disp_c", disp_c, '0);
    chk("post_rst_done", MB'(done), '0);
    chk("post_rst_run_count", MB'(run_count), '0);
    chk("post_rst_busy", MB'(busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
